// File: rtl/iter_alu.sv
// iter_alu: execute-stage ALU with one-cycle base ops and iterative
// unsigned multiply / divide / remainder (one step per clock).
// The result, zero and msb flags are registered and change only when
// done pulses or on reset. WIDTH must be a power of two and at least 4.

module iter_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [3:0]       selector,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out0,
  output logic             zero,
  output logic             msb
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_MULDIV = 1'b1
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;

  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [SHW-1:0]   CNT_ONE   = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0]   LAST_STEP = {SHW{1'b1}};

  // Single-cycle result of the base ops; reserved codes yield zero.
  function automatic logic [WIDTH-1:0] basic_op(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] r;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $unsigned($signed(a) >>> sh);
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
      default: r = ZERO_W;
    endcase
    return r;
  endfunction

  // Codes 10..13 run through the iterative datapath.
  function automatic logic is_iter_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  state_t           state_r;
  logic [SHW-1:0]   cnt_r;
  logic [3:0]       sel_r;
  logic [WIDTH-1:0] b_r;
  // Shared working pair: multiply keeps {product high, multiplier/product low},
  // divide keeps {partial remainder, dividend/quotient}.
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] out0_r;
  logic             zero_r;
  logic             msb_r;

  logic             is_div_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH:0]   div_diff_s;
  logic [WIDTH-1:0] hi_next_s;
  logic [WIDTH-1:0] lo_next_s;
  logic [WIDTH-1:0] iter_res_s;
  logic [WIDTH-1:0] basic_res_s;

  assign busy = busy_r;
  assign done = done_r;
  assign out0 = out0_r;
  assign zero = zero_r;
  assign msb  = msb_r;

  // Decode whether the latched op is a divide-family op.
  always_comb begin
    is_div_s = 1'b0;
    case (sel_r)
      OP_DIVU, OP_REMU: is_div_s = 1'b1;
      default:          is_div_s = 1'b0;
    endcase
  end

  // One shift-add multiply step or one restoring shift-subtract divide step.
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + {1'b0, (lo_r[0] ? b_r : ZERO_W)};
    div_shift_s = {hi_r, lo_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, b_r};
    hi_next_s   = hi_r;
    lo_next_s   = lo_r;
    if (is_div_s) begin
      // A clear sign bit means the divisor fits: keep the difference, quotient bit 1.
      // A zero divisor always fits, giving an all-ones quotient and remainder = dividend.
      if (!div_diff_s[WIDTH]) begin
        hi_next_s = div_diff_s[WIDTH-1:0];
        lo_next_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        hi_next_s = div_shift_s[WIDTH-1:0];
        lo_next_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Carry out of the add shifts into the top of the high half.
      hi_next_s = mul_sum_s[WIDTH:1];
      lo_next_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Pick the half of the working pair that holds the requested result.
  always_comb begin
    iter_res_s = lo_next_s;
    case (sel_r)
      OP_MUL:   iter_res_s = lo_next_s;
      OP_MULHU: iter_res_s = hi_next_s;
      OP_DIVU:  iter_res_s = lo_next_s;
      OP_REMU:  iter_res_s = hi_next_s;
      default:  iter_res_s = lo_next_s;
    endcase
  end

  // Base-op result straight from the live inputs at the accepting edge.
  always_comb begin
    basic_res_s = basic_op(selector, in0, in1);
  end

  // Control FSM plus all registered outputs and iterative state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {SHW{1'b0}};
      sel_r   <= 4'd0;
      b_r     <= ZERO_W;
      hi_r    <= ZERO_W;
      lo_r    <= ZERO_W;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      out0_r  <= ZERO_W;
      zero_r  <= 1'b1;
      msb_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (is_iter_op(selector)) begin
              sel_r   <= selector;
              b_r     <= in1;
              hi_r    <= ZERO_W;
              lo_r    <= in0;
              cnt_r   <= {SHW{1'b0}};
              busy_r  <= 1'b1;
              state_r <= ST_MULDIV;
            end else begin
              out0_r <= basic_res_s;
              zero_r <= (basic_res_s == ZERO_W);
              msb_r  <= basic_res_s[WIDTH-1];
              done_r <= 1'b1;
            end
          end
        end
        ST_MULDIV: begin
          hi_r  <= hi_next_s;
          lo_r  <= lo_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          // The counter wraps back to zero on the final step.
          if (cnt_r == LAST_STEP) begin
            out0_r  <= iter_res_s;
            zero_r  <= (iter_res_s == ZERO_W);
            msb_r   <= iter_res_s[WIDTH-1];
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu at WIDTH=32 and WIDTH=8. Stimulus pushes
// expected results (from a plain-arithmetic model) with the cycle they are
// due; a monitor on the falling edge pops and compares on every done.

module tb_iter_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start32 = 1'b0;
  logic [31:0] a32 = 32'd0, b32 = 32'd0;
  logic [3:0]  sel32 = 4'd0;
  logic        busy32, done32, zero32, msb32;
  logic [31:0] out32;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0;
  logic [3:0]  sel8 = 4'd0;
  logic        busy8, done8, zero8, msb8;
  logic [7:0]  out8;

  typedef struct {
    logic [63:0] res;
    longint      due;
  } exp_t;

  exp_t   q32[$];
  exp_t   q8[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  iter_alu #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(start32), .in0(a32), .in1(b32),
    .selector(sel32), .busy(busy32), .done(done32), .out0(out32),
    .zero(zero32), .msb(msb32)
  );

  iter_alu #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .in0(a8), .in1(b8),
    .selector(sel8), .busy(busy8), .done(done8), .out0(out8),
    .zero(zero8), .msb(msb8)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: result of each op at width w computed with plain integer math.
  function automatic logic [63:0] model(input int w, input logic [3:0] op,
                                        input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, a, b;
    int          sh;
    longint      sa, sb, t;
    mask = (64'd1 << w) - 64'd1;
    a    = a_in & mask;
    b    = b_in & mask;
    sh   = int'(b % 64'(w));
    sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    case (op)
      4'd0:  return (a + b) & mask;
      4'd1:  return (a - b) & mask;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return (a << sh) & mask;
      4'd6:  return a >> sh;
      4'd7:  begin t = sa >>> sh; return t & mask; end
      4'd8:  return (sa < sb) ? 64'd1 : 64'd0;
      4'd9:  return (a < b) ? 64'd1 : 64'd0;
      4'd10: return (a * b) & mask;
      4'd11: return ((a * b) >> w) & mask;
      4'd12: return (b == 64'd0) ? mask : a / b;
      4'd13: return (b == 64'd0) ? a : a % b;
      default: return 64'd0;
    endcase
  endfunction

  // Wait (bounded) until the chosen DUT drops busy; returns just after that edge.
  task automatic wait_idle(input bit w8);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((w8 ? busy8 : busy32) && n < 200);
    if (w8 ? busy8 : busy32) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  // Drive one accepted op and push its expected result and due cycle.
  task automatic issue(input bit w8, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit keep_start);
    exp_t e;
    int   w;
    bit   it;
    w  = w8 ? 8 : 32;
    it = (op >= 4'd10 && op <= 4'd13);
    @(negedge clk);
    e.res = model(w, op, 64'(a), 64'(b));
    e.due = cyc + 1 + (it ? w : 0);
    if (w8) begin
      a8 = a[7:0]; b8 = b[7:0]; sel8 = op; start8 = 1'b1;
      q8.push_back(e);
    end else begin
      a32 = a; b32 = b; sel32 = op; start32 = 1'b1;
      q32.push_back(e);
    end
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance: the op in flight must not notice.
    a32 = $urandom; b32 = $urandom; sel32 = 4'($urandom_range(0, 15));
    a8 = 8'($urandom); b8 = 8'($urandom); sel8 = 4'($urandom_range(0, 15));
    if (!keep_start) begin
      start32 = 1'b0;
      start8  = 1'b0;
    end
    if (it && !keep_start) wait_idle(w8);
  endtask

  task automatic check_reset_state();
    check("rst_busy32", busy32, 1'b0);
    check("rst_done32", done32, 1'b0);
    check("rst_out32", out32, 32'd0);
    check("rst_zero32", zero32, 1'b1);
    check("rst_msb32", msb32, 1'b0);
    check("rst_busy8", busy8, 1'b0);
    check("rst_out8", out8, 8'd0);
    check("rst_zero8", zero8, 1'b1);
  endtask

  // Monitor: compares every done against the scoreboard and checks output hold while busy.
  initial begin
    logic [31:0] held32;
    logic [7:0]  held8;
    exp_t        e;
    held32 = 32'd0;
    held8  = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy32 && !done32) check("hold_out32", out32, held32);
        if (busy8 && !done8) check("hold_out8", out8, held8);
        if (done32) begin
          if (q32.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL spurious_done32: done=1 with out0=0x%0h, expected no done", out32);
          end else begin
            e = q32.pop_front();
            check("out32", out32, e.res);
            check("zero32", zero32, e.res[31:0] == 32'd0);
            check("msb32", msb32, e.res[31]);
            check("latency32", cyc, e.due);
          end
        end
        if (done8) begin
          if (q8.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL spurious_done8: done=1 with out0=0x%0h, expected no done", out8);
          end else begin
            e = q8.pop_front();
            check("out8", out8, e.res);
            check("zero8", zero8, e.res[7:0] == 8'd0);
            check("msb8", msb8, e.res[7]);
            check("latency8", cyc, e.due);
          end
        end
      end
      held32 = out32;
      held8  = out8;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int          kind;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;

    // Directed base ops, including a chain with start held high.
    issue(1'b0, 4'd0, 32'd5, 32'd5, 1'b1);
    issue(1'b0, 4'd1, 32'd5, 32'd5, 1'b1);
    issue(1'b0, 4'd7, 32'h8000_0000, 32'd4, 1'b1);
    issue(1'b0, 4'd5, 32'b101, 32'd1, 1'b1);
    issue(1'b0, 4'd8, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue(1'b0, 4'd9, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue(1'b0, 4'd14, 32'd3, 32'd4, 1'b1);
    issue(1'b0, 4'd15, 32'd3, 32'd4, 1'b0);

    // Directed iterative ops, each issued at the first edge after busy drops.
    issue(1'b0, 4'd10, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(1'b0, 4'd11, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(1'b0, 4'd12, 32'd100, 32'd7, 1'b0);
    issue(1'b0, 4'd13, 32'd100, 32'd7, 1'b0);
    issue(1'b0, 4'd12, 32'd9, 32'd0, 1'b0);
    issue(1'b0, 4'd13, 32'd9, 32'd0, 1'b0);

    // Start pulsed mid-divide must be ignored entirely.
    issue(1'b0, 4'd12, 32'd100, 32'd7, 1'b1);
    start32 = 1'b0;
    repeat (4) @(negedge clk);
    a32 = 32'd1; b32 = 32'd2; sel32 = 4'd0; start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    wait_idle(1'b0);

    // Reset in the middle of a multiply discards it with no done.
    issue(1'b0, 4'd10, 32'hFFFF_FFFF, 32'd2, 1'b1);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    q32.delete();
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    issue(1'b0, 4'd4, 32'd1, 32'd1, 1'b0);

    // Randomized ops at WIDTH=32.
    for (int i = 0; i < 150; i++) begin
      op   = 4'($urandom_range(0, 15));
      a    = $urandom;
      kind = $urandom_range(0, 3);
      b    = (kind == 0) ? 32'd0 : (kind == 1) ? 32'($urandom_range(1, 40)) : $urandom;
      issue(1'b0, op, a, b, 1'b0);
    end

    // WIDTH=8: directed plan cases then random ops.
    issue(1'b1, 4'd10, 32'hFF, 32'd2, 1'b0);
    issue(1'b1, 4'd11, 32'hFF, 32'd2, 1'b0);
    issue(1'b1, 4'd12, 32'd100, 32'd7, 1'b0);
    issue(1'b1, 4'd13, 32'd100, 32'd7, 1'b0);
    issue(1'b1, 4'd12, 32'd9, 32'd0, 1'b0);
    issue(1'b1, 4'd13, 32'd9, 32'd0, 1'b0);
    issue(1'b1, 4'd7, 32'h80, 32'd3, 1'b0);
    for (int i = 0; i < 60; i++) begin
      op   = 4'($urandom_range(0, 15));
      kind = $urandom_range(0, 3);
      b    = (kind == 0) ? 32'd0 : 32'($urandom_range(0, 255));
      issue(1'b1, op, 32'($urandom_range(0, 255)), b, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q8_drained", 64'(q8.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
